// File: rtl/hdr_parser_pkg.sv
// Shared types for the header stream parser: FSM states, ctrl encodings, per-word tag bundle.
// No logic here beyond a saturating increment helper.
package hdr_parser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MODHDR,
    HDR,
    PAYLOAD
  } state_t;

  localparam logic [7:0] CTRL_MODHDR = 8'hFF;
  localparam logic [7:0] CTRL_DATA   = 8'h00;

  // Classification carried alongside ctrl/data in each buffer entry
  typedef struct packed {
    logic [15:0] count;
    logic        payload;
    logic        sop;
    logic        eop;
  } meta_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hdr_parser_skid_fifo.sv
// DEPTH-entry buffer with occupancy count; head entry is visible combinationally.
// Latency: an entry pushed at edge N can be popped at edge N+1.
// Backpressure: a push when full is ignored unless a pop happens in the same cycle.
module hdr_parser_skid_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/header_stream_parser.sv
// Tags a ctrl/data word stream with sop/eop/payload/count; HDR_PARSER_STATS_EN adds stat_pkts/stat_drops.
// Latency: a word accepted at edge N is presented with out_wr=1 after edge N+1.
// Backpressure: in_rdy falls when the DEPTH-entry buffer is full; writes while not ready are dropped.
module header_stream_parser
  import hdr_parser_pkg::*;
#(
  parameter int DWIDTH     = 64,
  parameter int CTRL_WIDTH = DWIDTH / 8,
  parameter int HDR_WORDS  = 5,
  parameter int DEPTH      = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [DWIDTH-1:0]     in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DWIDTH-1:0]     out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic [7:0]            cfg_hdr_words,
  output logic [15:0]           data_count,
  output logic                  o_inside_payload,
  output logic                  o_sop,
  output logic                  o_eop
`ifdef HDR_PARSER_STATS_EN
  ,
  output logic [31:0]           stat_pkts,
  output logic [31:0]           stat_drops
`endif
);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int EW   = CTRL_WIDTH + DWIDTH + $bits(meta_t);
  localparam logic [7:0]            HDR_DEF = 8'(HDR_WORDS);
  localparam logic [CTRL_WIDTH-1:0] C_MOD   = CTRL_WIDTH'(CTRL_MODHDR);
  localparam logic [CTRL_WIDTH-1:0] C_DATA  = CTRL_WIDTH'(CTRL_DATA);

  state_t                state, state_nxt;
  logic [7:0]            hdr_cnt, hdr_nxt, eff_hdr, eff_nxt, cfg_eff, eff_use, idx;
  logic [15:0]           pay_cnt, pay_nxt;
  logic                  is_mod, is_data, is_eop, push, pop;
  meta_t                 meta, head_meta;
  logic [CNTW-1:0]       occ;
  logic [EW-1:0]         head_dat;
  logic [DWIDTH-1:0]     head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;

  assign in_rdy  = occ < CNTW'(DEPTH);
  assign push    = in_wr && in_rdy;
  assign pop     = out_rdy && (occ != '0);
  assign is_mod  = (in_ctrl == C_MOD);
  assign is_data = (in_ctrl == C_DATA);
  assign is_eop  = !is_mod && !is_data;
  assign cfg_eff = (cfg_hdr_words == 8'd0) ? HDR_DEF : cfg_hdr_words;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      hdr_cnt <= '0;
      pay_cnt <= '0;
      eff_hdr <= '0;
    end else begin
      state   <= state_nxt;
      hdr_cnt <= hdr_nxt;
      pay_cnt <= pay_nxt;
      eff_hdr <= eff_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hdr_nxt   = hdr_cnt;
    pay_nxt   = pay_cnt;
    eff_nxt   = eff_hdr;
    meta      = '0;
    idx       = (state == HDR) ? hdr_cnt : 8'd0;
    // The sop word has not latched its header count yet, so it uses cfg directly
    eff_use   = (state == IDLE) ? cfg_eff : eff_hdr;
    if (push) begin
      if (state == IDLE) begin
        meta.sop = !is_eop;
        eff_nxt  = cfg_eff;
      end
      if (is_eop) begin
        meta.eop  = 1'b1;
        state_nxt = IDLE;
        if (state == PAYLOAD) begin
          meta.payload = 1'b1;
          meta.count   = sat_inc(pay_cnt);
        end
      end else if (state == PAYLOAD) begin
        meta.payload = 1'b1;
        meta.count   = sat_inc(pay_cnt);
        pay_nxt      = meta.count;
      end else if (is_mod) begin
        if (state == IDLE) state_nxt = MODHDR;
      end else if (idx == eff_use) begin
        state_nxt    = PAYLOAD;
        meta.payload = 1'b1;
        pay_nxt      = '0;
      end else begin
        state_nxt = HDR;
        hdr_nxt   = idx + 8'd1;
      end
    end
  end

  hdr_parser_skid_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk      (i_clock),
    .rst_n    (i_reset_n),
    .push     (push),
    .push_dat ({in_ctrl, in_data, meta}),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (occ)
  );

  assign {head_ctrl, head_data, head_meta} = head_dat;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_wr           <= 1'b0;
      out_data         <= '0;
      out_ctrl         <= '0;
      data_count       <= '0;
      o_inside_payload <= 1'b0;
      o_sop            <= 1'b0;
      o_eop            <= 1'b0;
    end else begin
      out_wr <= pop;
      if (pop) begin
        out_data         <= head_data;
        out_ctrl         <= head_ctrl;
        data_count       <= head_meta.count;
        o_inside_payload <= head_meta.payload;
        o_sop            <= head_meta.sop;
        o_eop            <= head_meta.eop;
      end
    end
  end

`ifdef HDR_PARSER_STATS_EN
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stat_pkts  <= '0;
      stat_drops <= '0;
    end else begin
      if (push && meta.eop)  stat_pkts  <= stat_pkts + 32'd1;
      if (in_wr && !in_rdy)  stat_drops <= stat_drops + 32'd1;
    end
  end
`endif

endmodule
